// File: rtl/word_ser_pkg.sv
// word_ser_pkg: shared state encoding, byte width and counter sizing for word_serializer.
package word_ser_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RISE,
        WAIT_FALL
    } state_t;

    // Bits needed to hold a down-counter starting at n (inclusive).
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/word_ser_shreg.sv
// word_ser_shreg: word shift register with parallel load, byte shift in either direction
// and a head-byte tap that follows the selected direction.
module word_ser_shreg
    import word_ser_pkg::*;
#(
    parameter int unsigned N = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              lsb_i,
    input  logic [N-1:0]      data_i,
    output logic [BYTE_W-1:0] head_o
);

    logic [N-1:0] data_q, data_d;

    always_comb begin
        data_d = load_i  ? data_i :
                 shift_i ? (lsb_i ? data_q >> BYTE_W : data_q << BYTE_W) :
                 data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign head_o = lsb_i ? data_q[BYTE_W-1:0] : data_q[N-1 -: BYTE_W];

endmodule

// File: rtl/word_serializer.sv
// word_serializer: splits an N-bit word into bytes paced by the UART busy rise/fall handshake.
// Optional WORD_SER_CSUM_EN appends an XOR checksum byte after the data bytes.
module word_serializer
    import word_ser_pkg::*;
#(
    parameter int unsigned N = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    input  logic              in_lsb_first,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NB = N / BYTE_W;
`ifdef WORD_SER_CSUM_EN
    localparam int unsigned NTOT = NB + 1;
`else
    localparam int unsigned NTOT = NB;
`endif
    localparam int unsigned CW = cnt_w(NTOT);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              lsb_q, lsb_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic              done_q, done_d;
    logic              accept, load, shift;
    logic [BYTE_W-1:0] head, next_byte;

    assign in_ready = (state_q == IDLE) && !tx_busy;
    assign accept   = in_valid && in_ready;
    assign load     = accept;
    assign shift    = (state_q == SEND);
    assign busy     = (state_q != IDLE);
    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;

    word_ser_shreg #(.N(N)) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .shift_i(shift),
        .lsb_i  (lsb_q),
        .data_i (in_data),
        .head_o (head)
    );

`ifdef WORD_SER_CSUM_EN
    logic [BYTE_W-1:0] acc_q, acc_d;
    // The byte being sent is folded in during SEND, so the sum is complete by the last slot.
    always_comb begin
        acc_d = accept ? '0 : (state_q == SEND) ? acc_q ^ tx_byte_q : acc_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
    assign next_byte = (cnt_q == CW'(1)) ? acc_q : head;
`else
    assign next_byte = head;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lsb_d      = lsb_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d    = SEND;
                cnt_d      = CW'(NTOT);
                lsb_d      = in_lsb_first;
                tx_valid_d = 1'b1;
                tx_byte_d  = in_lsb_first ? in_data[BYTE_W-1:0] : in_data[N-1 -: BYTE_W];
            end
            SEND: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = WAIT_RISE;
            end
            WAIT_RISE: state_d = tx_busy ? WAIT_FALL : WAIT_RISE;
            WAIT_FALL: if (!tx_busy) begin
                state_d    = (cnt_q != '0) ? SEND : IDLE;
                tx_valid_d = (cnt_q != '0);
                done_d     = (cnt_q == '0);
                tx_byte_d  = (cnt_q != '0) ? next_byte : tx_byte_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lsb_q      <= 1'b0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lsb_q      <= lsb_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed checks of word_serializer (N=32) against a UART busy model.
// Expected byte streams follow WORD_SER_CSUM_EN when it is defined.
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_lsb_first = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_busy;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    int          ucnt = 0;
    logic        uart_en = 1'b1;
    int          ndone = 0;
    logic [7:0]  got[$];

`ifdef WORD_SER_CSUM_EN
    localparam int NEXP = 5;
`else
    localparam int NEXP = 4;
`endif

    word_serializer #(.N(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_lsb_first(in_lsb_first),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles starting the cycle after each start pulse.
    always @(posedge clk) begin
        if (tx_valid && uart_en) ucnt <= 10;
        else if (ucnt > 0)       ucnt <= ucnt - 1;
    end
    assign tx_busy = (ucnt != 0);

    always @(posedge clk) begin
        if (tx_valid) got.push_back(tx_byte);
        if (done) ndone++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic lsb);
        @(negedge clk);
        in_data      = w;
        in_lsb_first = lsb;
        in_valid     = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        check("send_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n0 = ndone;
        for (int i = 0; i < 300 && ndone == n0; i++) @(negedge clk);
        check({tag, "_done"}, ndone - n0, 32'd1);
    endtask

    task automatic check_seq(input string tag, input logic [31:0] exp, input logic [7:0] csum);
        check({tag, "_count"}, got.size(), NEXP);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'b0, got[i]} : 32'hxxxx_xxxx,
                  {24'b0, exp[31-8*i -: 8]});
        if (NEXP == 5)
            check({tag, "_csum"}, (got.size() > 4) ? {24'b0, got[4]} : 32'hxxxx_xxxx, {24'b0, csum});
    endtask

    initial begin
        int rdy_seen;
        int n0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_byte", {24'b0, tx_byte}, 32'h00);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;

        got.delete();
        send(32'hA1B2C3D4, 1'b0);
        check("msb_first_valid", {31'b0, tx_valid}, 32'd1);
        check("msb_first_byte", {24'b0, tx_byte}, 32'hA1);
        check("msb_busy", {31'b0, busy}, 32'd1);
        wait_done("msb");
        check_seq("msb", 32'hA1B2C3D4, 8'h04);

        got.delete();
        send(32'hA1B2C3D4, 1'b1);
        check("lsb_first_byte", {24'b0, tx_byte}, 32'hD4);
        wait_done("lsb");
        check_seq("lsb", 32'hD4C3B2A1, 8'h04);

        // Second word held on the input for the whole first transfer.
        got.delete();
        send(32'hA1B2C3D4, 1'b0);
        in_data  = 32'h11223344;
        in_valid = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
        end
        check("hold_done_seen", {31'b0, done}, 32'd1);
        check("hold_ready_blocked", rdy_seen, 32'd0);
        check("hold_ready_at_done", {31'b0, in_ready}, 32'd1);
        check_seq("hold_w1", 32'hA1B2C3D4, 8'h04);
        got.delete();
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_w2_first", {24'b0, tx_byte}, 32'h11);
        check("hold_w2_valid", {31'b0, tx_valid}, 32'd1);
        wait_done("hold_w2");
        check_seq("hold_w2", 32'h11223344, 8'h44);

        // Reset after the second byte of a word.
        got.delete();
        send(32'h55667788, 1'b0);
        for (int i = 0; i < 100 && got.size() < 2; i++) @(negedge clk);
        check("rst_mid_two_bytes", got.size(), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_tx_valid", {31'b0, tx_valid}, 32'd0);
        got.delete();
        n0 = ndone;
        repeat (30) @(negedge clk);
        check("rst_mid_no_bytes", got.size(), 32'd0);
        check("rst_mid_no_done", ndone - n0, 32'd0);
        check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        send(32'h0A0B0C0D, 1'b0);
        wait_done("after_rst");
        check_seq("after_rst", 32'h0A0B0C0D, 8'h00);

        // UART never raises busy: the block must park in WAIT_RISE.
        uart_en = 1'b0;
        got.delete();
        n0 = ndone;
        send(32'hCAFEF00D, 1'b0);
        check("stall_first_byte", {24'b0, tx_byte}, 32'hCA);
        repeat (25) @(negedge clk);
        check("stall_busy", {31'b0, busy}, 32'd1);
        check("stall_one_byte", got.size(), 32'd1);
        check("stall_no_done", ndone - n0, 32'd0);
        check("stall_ready", {31'b0, in_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
